single_port_memory_arbiter: RTL and testbench
=============================================

Name: single_port_memory_arbiter

Overview:
Two-requester front end for the team's single-port RAM. It accepts read and write requests from port A and port B using valid/ready handshakes, and issues at most one access per cycle using round-robin arbitration. It drives the RAM address, write-enable and data lines. Read data returns as a registered per-port response that honours backpressure. The block sits directly upstream of the RAM, and RAM data_out feeds back into it.

Parameters:
DATAWIDTH, 8, word width; must match the RAM.
DATADEPTH, 1024, number of words; must match the RAM.
ADDRESSWIDTH, $clog2(DATADEPTH), address width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
a_req_valid  input  1  port A request valid.
a_req_ready  output  1  port A request accepted this cycle (combinational grant).
a_req_write  input  1  1 = write, 0 = read.
a_req_address  input  ADDRESSWIDTH  port A address.
a_req_wdata  input  DATAWIDTH  port A write data.
a_rsp_valid  output  1  port A read data valid.
a_rsp_ready  input  1  port A consumes the response.
a_rsp_rdata  output  DATAWIDTH  port A read data.
b_*  (same set as port A)  port B.
mem_write_en  output  1  to RAM write_en.
mem_address  output  ADDRESSWIDTH  to RAM address.
mem_data_in  output  DATAWIDTH  to RAM data_in.
mem_data_out  input  DATAWIDTH  from RAM; reflects the address presented on the previous cycle.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - read_pend_a/b = 0, rsp_valid = 0, rsp_rdata = 0, last_grant = B (so A wins the first tie).
  - Outputs during reset: req_ready = 0, mem_write_en = 0.
  - RAM contents are not touched.
- Eligibility:
  - A write is always eligible.
  - A read on port p is eligible only if read_pend_p = 0 and not (p_rsp_valid && !p_rsp_ready).
  - A port with a blocked read stalls; its request is not reordered.
- Arbitration:
  - Exactly one eligible port: it wins.
  - Both eligible: the port not equal to last_grant wins; last_grant updates on every grant.
  - Neither eligible: no grant; last_grant holds.
- Grant cycle N:
  - req_ready of the winner = 1; the other port's req_ready = 0.
  - mem_address, mem_data_in and mem_write_en (= req_write) are driven combinationally from the winner.
  - No grant: mem_write_en = 0, mem_address = 0, mem_data_in = 0.
- Write: the RAM updates at the end of cycle N. No response is produced.
- Read, fixed latency:
  - End of N: read_pend_p sets.
  - Cycle N+1: mem_data_out is valid. At the end of N+1, rsp_rdata_p captures it, rsp_valid_p sets and read_pend_p clears.
  - rsp_valid_p is therefore first visible in cycle N+2.
  - The response holds (valid and data stable) until the rsp_ready handshake. It then clears, unless a new capture occurs on the same edge, in which case the new data loads and valid stays 1.
- Throughput:
  - Writes: one per cycle total.
  - Reads: one per 2 cycles per port; A and B reads may interleave every cycle.
- Hazards:
  - Read at N, write to the same address at N+1: the read returns the old data (read-before-write).
  - Write at N, read at N+1: the read returns the new data.
- Reset asserted mid-operation discards any in-flight read. No response appears after reset releases.

Decomposition:
- Package single_port_memory_arbiter_pkg:
  - typedef enum logic {PORT_A, PORT_B} port_t
  - typedef struct packed {write, address, wdata} mem_req_t, parameterised via localparams in the instantiating scope; struct widths are passed by parameter, not fixed in the package.
- Sub-module rr_arbiter_2: inputs req[1:0], advance; output grant[1:0]; holds last_grant, reset via reset_n.
- The top instantiates one rr_arbiter_2 plus two identical per-port response registers (generate or duplicated always_ff).

Test Plan:
- Reset, then A writes 0x5A @ 0x010 at cycle 1 and reads @ 0x010 at cycle 2 -> a_rsp_valid = 1 at cycle 4 with rdata = 0x5A; mem_write_en pulses only at cycle 1.
- Both ports request reads every cycle (A @ 0x001, B @ 0x002, preloaded 0x11/0x22) -> grants alternate A, B, A, B. Responses: A 0x11 at cycles 3, 5, …; B 0x22 at cycles 4, 6, ….
- Hold a_rsp_ready = 0 after an A read -> rsp_valid and rdata stay stable; a_req_ready = 0 for further A reads while A writes are still granted. Raise ready -> 1-cycle handshake, then the next A read is granted.
- A reads 0x020 at N (old value 0x33) and B writes 0x44 @ 0x020 at N+1 -> A gets 0x33. A read at N+2 -> 0x44.
- Pulse reset_n low during cycle N+1 of a read -> no rsp_valid ever appears for it. After release, A wins the first simultaneous request.
- No requests for 10 cycles -> mem_write_en = 0, all req_ready = 0, all rsp_valid = 0.

Source files
------------

// File: rtl/single_port_memory_arbiter_pkg.sv
// Shared types and defaults for the two-port single-port-RAM arbiter.
package single_port_memory_arbiter_pkg;

   // Requester identity; also the encoding of the round-robin history.
   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

   localparam int DEFAULT_DATAWIDTH = 8;
   localparam int DEFAULT_DATADEPTH = 1024;

   // A read may issue only when nothing is in flight for the port and its
   // response slot is empty or being drained this cycle.
   function automatic logic read_eligible(input logic pend,
                                          input logic rsp_valid,
                                          input logic rsp_ready);
      return !pend && !(rsp_valid && !rsp_ready);
   endfunction

endpackage

// File: rtl/single_port_memory_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter. On a tie the port that did not win last
// time is granted; the history only moves when a grant is actually taken.
module rr_arbiter_2
   import single_port_memory_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   port_t last_grant_q;
   port_t last_grant_d;

   // Grant selection: a lone requester wins, a tie goes to the other port.
   always_comb begin
      grant_o = 2'b00;
      if (req_i == 2'b11) begin
         grant_o = (last_grant_q == PORT_A) ? 2'b10 : 2'b01;
      end else begin
         grant_o = req_i;
      end
   end

   // History update: remember the winner of every taken grant.
   always_comb begin
      last_grant_d = last_grant_q;
      if (advance_i && grant_o[0]) begin
         last_grant_d = PORT_A;
      end else if (advance_i && grant_o[1]) begin
         last_grant_d = PORT_B;
      end
   end

   // History register; resets to B so that A wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= PORT_B;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/single_port_memory_arbiter.sv
// Front end for a single-port RAM shared by two requesters (A and B).
// Handshake: a request transfers in the cycle where req_valid and req_ready
// are both high (req_ready is the combinational grant); a response transfers
// in the cycle where rsp_valid and rsp_ready are both high, and rsp_valid /
// rsp_rdata stay stable until then.
// Read timing: grant in N, RAM data in N+1, registered response from N+2.
module single_port_memory_arbiter
   import single_port_memory_arbiter_pkg::*;
#(
   parameter int DATAWIDTH    = DEFAULT_DATAWIDTH,
   parameter int DATADEPTH    = DEFAULT_DATADEPTH,
   parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    a_req_valid,
   output logic                    a_req_ready,
   input  logic                    a_req_write,
   input  logic [ADDRESSWIDTH-1:0] a_req_address,
   input  logic [DATAWIDTH-1:0]    a_req_wdata,
   output logic                    a_rsp_valid,
   input  logic                    a_rsp_ready,
   output logic [DATAWIDTH-1:0]    a_rsp_rdata,
   input  logic                    b_req_valid,
   output logic                    b_req_ready,
   input  logic                    b_req_write,
   input  logic [ADDRESSWIDTH-1:0] b_req_address,
   input  logic [DATAWIDTH-1:0]    b_req_wdata,
   output logic                    b_rsp_valid,
   input  logic                    b_rsp_ready,
   output logic [DATAWIDTH-1:0]    b_rsp_rdata,
   output logic                    mem_write_en,
   output logic [ADDRESSWIDTH-1:0] mem_address,
   output logic [DATAWIDTH-1:0]    mem_data_in,
   input  logic [DATAWIDTH-1:0]    mem_data_out
);

   typedef struct packed {
      logic                    write;
      logic [ADDRESSWIDTH-1:0] address;
      logic [DATAWIDTH-1:0]    wdata;
   } mem_req_t;

   mem_req_t             req     [2];
   mem_req_t             win_req;
   logic [1:0]           req_valid;
   logic [1:0]           rsp_ready;
   logic [1:0]           eligible;
   logic [1:0]           grant;
   logic [1:0]           pend;
   logic [1:0]           rsp_valid;
   logic [DATAWIDTH-1:0] rsp_rdata [2];

   assign req[0]    = '{write: a_req_write, address: a_req_address, wdata: a_req_wdata};
   assign req[1]    = '{write: b_req_write, address: b_req_address, wdata: b_req_wdata};
   assign req_valid = {b_req_valid, a_req_valid};
   assign rsp_ready = {b_rsp_ready, a_rsp_ready};

   // Eligibility: writes always qualify, reads only with a free response
   // slot. Held in reset so nothing is granted while reset_n is low.
   always_comb begin
      eligible = 2'b00;
      for (int p = 0; p < 2; p++) begin
         eligible[p] = reset_n && req_valid[p] &&
                       (req[p].write || read_eligible(pend[p], rsp_valid[p], rsp_ready[p]));
      end
   end

   rr_arbiter_2 u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_i     (eligible),
      .advance_i (|eligible),
      .grant_o   (grant)
   );

   // RAM request mux: winner's fields, or all-zero when idle.
   always_comb begin
      win_req = '0;
      if (grant[0]) begin
         win_req = req[0];
      end else if (grant[1]) begin
         win_req = req[1];
      end
   end

   assign mem_write_en = win_req.write;
   assign mem_address  = win_req.address;
   assign mem_data_in  = win_req.wdata;
   assign a_req_ready  = grant[0];
   assign b_req_ready  = grant[1];

   for (genvar p = 0; p < 2; p++) begin : g_rsp
      logic                 pend_q;
      logic                 pend_d;
      logic                 valid_q;
      logic                 valid_d;
      logic [DATAWIDTH-1:0] rdata_q;
      logic [DATAWIDTH-1:0] rdata_d;

      // Response slot: capture RAM data the cycle after a read grant; a
      // capture on the handshake edge reloads instead of clearing.
      always_comb begin
         pend_d  = grant[p] && !req[p].write;
         valid_d = valid_q;
         rdata_d = rdata_q;
         if (pend_q) begin
            valid_d = 1'b1;
            rdata_d = mem_data_out;
         end else if (valid_q && rsp_ready[p]) begin
            valid_d = 1'b0;
         end
      end

      // Response state; reset drops any in-flight read.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
         end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
         end
      end

      assign pend[p]      = pend_q;
      assign rsp_valid[p] = valid_q;
      assign rsp_rdata[p] = rdata_q;
   end

   assign a_rsp_valid = rsp_valid[0];
   assign b_rsp_valid = rsp_valid[1];
   assign a_rsp_rdata = rsp_rdata[0];
   assign b_rsp_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_single_port_memory_arbiter.sv
// Directed bench for single_port_memory_arbiter with a behavioural
// read-before-write RAM (data_out registered from the previous address).
module tb_single_port_memory_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       a_req_valid, a_req_ready, a_req_write;
   logic [9:0] a_req_address;
   logic [7:0] a_req_wdata;
   logic       a_rsp_valid, a_rsp_ready;
   logic [7:0] a_rsp_rdata;
   logic       b_req_valid, b_req_ready, b_req_write;
   logic [9:0] b_req_address;
   logic [7:0] b_req_wdata;
   logic       b_rsp_valid, b_rsp_ready;
   logic [7:0] b_rsp_rdata;
   logic       mem_write_en;
   logic [9:0] mem_address;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out = 8'h00;
   logic [7:0] ram [1024];

   // {a_req_ready, b_req_ready, mem_write_en, a_rsp_valid, b_rsp_valid}
   logic [4:0] obs;
   int         vec_cnt = 0;
   int         err_cnt = 0;

   assign obs = {a_req_ready, b_req_ready, mem_write_en, a_rsp_valid, b_rsp_valid};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_en) ram[mem_address] <= mem_data_in;
      mem_data_out <= ram[mem_address];
   end

   single_port_memory_arbiter dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .a_req_valid   (a_req_valid),
      .a_req_ready   (a_req_ready),
      .a_req_write   (a_req_write),
      .a_req_address (a_req_address),
      .a_req_wdata   (a_req_wdata),
      .a_rsp_valid   (a_rsp_valid),
      .a_rsp_ready   (a_rsp_ready),
      .a_rsp_rdata   (a_rsp_rdata),
      .b_req_valid   (b_req_valid),
      .b_req_ready   (b_req_ready),
      .b_req_write   (b_req_write),
      .b_req_address (b_req_address),
      .b_req_wdata   (b_req_wdata),
      .b_rsp_valid   (b_rsp_valid),
      .b_rsp_ready   (b_rsp_ready),
      .b_rsp_rdata   (b_rsp_rdata),
      .mem_write_en  (mem_write_en),
      .mem_address   (mem_address),
      .mem_data_in   (mem_data_in),
      .mem_data_out  (mem_data_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic w, input logic [9:0] ad, input logic [7:0] d);
      a_req_valid = v; a_req_write = w; a_req_address = ad; a_req_wdata = d;
   endtask

   task automatic drv_b(input logic v, input logic w, input logic [9:0] ad, input logic [7:0] d);
      b_req_valid = v; b_req_write = w; b_req_address = ad; b_req_wdata = d;
   endtask

   task automatic idle_reqs();
      drv_a(1'b0, 1'b0, 10'h000, 8'h00);
      drv_b(1'b0, 1'b0, 10'h000, 8'h00);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;
      drv_a(1'b1, 1'b1, 10'h005, 8'hAA);
      drv_b(1'b1, 1'b0, 10'h006, 8'h00);
      #3;
      vec_cnt++;
      if (obs !== 5'b00000) begin
         err_cnt++; $display("FAIL reset_flags got %b exp %b", obs, 5'b00000);
      end
      vec_cnt++;
      if ({a_rsp_rdata, b_rsp_rdata} !== 16'h0000) begin
         err_cnt++; $display("FAIL reset_rdata got %h exp %h", {a_rsp_rdata, b_rsp_rdata}, 16'h0000);
      end
      step();
      step();
      idle_reqs();
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      // cycle 1: write 0x5A @ 0x010
      drv_a(1'b1, 1'b1, 10'h010, 8'h5A);
      @(negedge clk);
      vec_cnt++;
      if (obs !== 5'b10100) begin
         err_cnt++; $display("FAIL wr_flags got %b exp %b", obs, 5'b10100);
      end
      vec_cnt++;
      if ({mem_address, mem_data_in} !== {10'h010, 8'h5A}) begin
         err_cnt++; $display("FAIL wr_bus got %h/%h exp 010/5a", mem_address, mem_data_in);
      end
      step();
      // cycle 2: read @ 0x010
      drv_a(1'b1, 1'b0, 10'h010, 8'h00);
      @(negedge clk);
      vec_cnt++;
      if (obs !== 5'b10000) begin
         err_cnt++; $display("FAIL rd_flags got %b exp %b", obs, 5'b10000);
      end
      vec_cnt++;
      if (mem_address !== 10'h010) begin
         err_cnt++; $display("FAIL rd_addr got %h exp 010", mem_address);
      end
      step();
      idle_reqs();
      // cycle 3: nothing visible yet
      @(negedge clk);
      vec_cnt++;
      if (obs !== 5'b00000) begin
         err_cnt++; $display("FAIL rd_c3_flags got %b exp %b", obs, 5'b00000);
      end
      step();
      // cycle 4: response, consumed immediately
      @(negedge clk);
      vec_cnt++;
      if (obs !== 5'b00010) begin
         err_cnt++; $display("FAIL rd_c4_flags got %b exp %b", obs, 5'b00010);
      end
      vec_cnt++;
      if (a_rsp_rdata !== 8'h5A) begin
         err_cnt++; $display("FAIL rd_c4_data got %h exp 5a", a_rsp_rdata);
      end
      step();
      @(negedge clk);
      vec_cnt++;
      if (obs !== 5'b00000) begin
         err_cnt++; $display("FAIL rd_c5_flags got %b exp %b", obs, 5'b00000);
      end
      step();
   endtask

   task automatic test_interleave();
      logic [4:0] exp;
      drv_a(1'b1, 1'b1, 10'h001, 8'h11);
      step();
      drv_a(1'b0, 1'b0, 10'h000, 8'h00);
      drv_b(1'b1, 1'b1, 10'h002, 8'h22);
      step();
      // last grant is now B, so A takes the first tie
      for (int t = 0; t < 6; t++) begin
         drv_a(1'b1, 1'b0, 10'h001, 8'h00);
         drv_b(1'b1, 1'b0, 10'h002, 8'h00);
         exp = {(t % 2 == 0), (t % 2 == 1), 1'b0, (t >= 2 && t % 2 == 0), (t >= 3 && t % 2 == 1)};
         @(negedge clk);
         vec_cnt++;
         if (obs !== exp) begin
            err_cnt++; $display("FAIL ilv_t%0d_flags got %b exp %b", t, obs, exp);
         end
         if (exp[1]) begin
            vec_cnt++;
            if (a_rsp_rdata !== 8'h11) begin
               err_cnt++; $display("FAIL ilv_t%0d_adata got %h exp 11", t, a_rsp_rdata);
            end
         end
         if (exp[0]) begin
            vec_cnt++;
            if (b_rsp_rdata !== 8'h22) begin
               err_cnt++; $display("FAIL ilv_t%0d_bdata got %h exp 22", t, b_rsp_rdata);
            end
         end
         step();
      end
      idle_reqs();
      step();
      step();
      @(negedge clk);
      vec_cnt++;
      if (obs !== 5'b00000) begin
         err_cnt++; $display("FAIL ilv_drain_flags got %b exp %b", obs, 5'b00000);
      end
      step();
   endtask

   task automatic test_backpressure();
      logic [4:0] exp_f [10] = '{5'b10000, 5'b00000, 5'b00010, 5'b00010, 5'b10110,
                                 5'b00010, 5'b10010, 5'b00000, 5'b00010, 5'b00000};
      a_rsp_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         case (c)
            0, 1, 2, 3: drv_a(1'b1, 1'b0, 10'h010, 8'h00);
            4:          drv_a(1'b1, 1'b1, 10'h030, 8'h77);
            5:          drv_a(1'b1, 1'b0, 10'h030, 8'h00);
            6:          begin drv_a(1'b1, 1'b0, 10'h030, 8'h00); a_rsp_ready = 1'b1; end
            default:    drv_a(1'b0, 1'b0, 10'h000, 8'h00);
         endcase
         @(negedge clk);
         vec_cnt++;
         if (obs !== exp_f[c]) begin
            err_cnt++; $display("FAIL bp_c%0d_flags got %b exp %b", c, obs, exp_f[c]);
         end
         if (c >= 2 && c <= 6) begin
            vec_cnt++;
            if (a_rsp_rdata !== 8'h5A) begin
               err_cnt++; $display("FAIL bp_c%0d_hold got %h exp 5a", c, a_rsp_rdata);
            end
         end
         if (c == 8) begin
            vec_cnt++;
            if (a_rsp_rdata !== 8'h77) begin
               err_cnt++; $display("FAIL bp_c8_data got %h exp 77", a_rsp_rdata);
            end
         end
         step();
      end
   endtask

   task automatic test_hazard();
      logic [4:0] exp_f [7] = '{5'b10100, 5'b10000, 5'b01100, 5'b10010,
                                5'b00000, 5'b00010, 5'b00000};
      for (int c = 0; c < 7; c++) begin
         idle_reqs();
         case (c)
            0: drv_a(1'b1, 1'b1, 10'h020, 8'h33);
            1: drv_a(1'b1, 1'b0, 10'h020, 8'h00);
            2: drv_b(1'b1, 1'b1, 10'h020, 8'h44);
            3: drv_a(1'b1, 1'b0, 10'h020, 8'h00);
            default: ;
         endcase
         @(negedge clk);
         vec_cnt++;
         if (obs !== exp_f[c]) begin
            err_cnt++; $display("FAIL hz_c%0d_flags got %b exp %b", c, obs, exp_f[c]);
         end
         if (c == 3) begin
            vec_cnt++;
            if (a_rsp_rdata !== 8'h33) begin
               err_cnt++; $display("FAIL hz_old_data got %h exp 33", a_rsp_rdata);
            end
         end
         if (c == 5) begin
            vec_cnt++;
            if (a_rsp_rdata !== 8'h44) begin
               err_cnt++; $display("FAIL hz_new_data got %h exp 44", a_rsp_rdata);
            end
         end
         step();
      end
      idle_reqs();
   endtask

   task automatic test_reset_mid();
      drv_a(1'b1, 1'b0, 10'h010, 8'h00);
      @(negedge clk);
      vec_cnt++;
      if (obs !== 5'b10000) begin
         err_cnt++; $display("FAIL rm_grant_flags got %b exp %b", obs, 5'b10000);
      end
      step();
      // cycle N+1: pulse reset while requests are presented
      reset_n = 1'b0;
      drv_a(1'b1, 1'b1, 10'h040, 8'h99);
      drv_b(1'b1, 1'b1, 10'h041, 8'h98);
      #2;
      vec_cnt++;
      if (obs !== 5'b00000) begin
         err_cnt++; $display("FAIL rm_in_reset_flags got %b exp %b", obs, 5'b00000);
      end
      idle_reqs();
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      step();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vec_cnt++;
         if (obs !== 5'b00000) begin
            err_cnt++; $display("FAIL rm_after_c%0d_flags got %b exp %b", c, obs, 5'b00000);
         end
         step();
      end
      drv_a(1'b1, 1'b1, 10'h040, 8'h99);
      drv_b(1'b1, 1'b1, 10'h041, 8'h98);
      @(negedge clk);
      vec_cnt++;
      if ({obs, mem_address} !== {5'b10100, 10'h040}) begin
         err_cnt++; $display("FAIL rm_first_tie got %b/%h exp 10100/040", obs, mem_address);
      end
      step();
      @(negedge clk);
      vec_cnt++;
      if ({obs, mem_address} !== {5'b01100, 10'h041}) begin
         err_cnt++; $display("FAIL rm_second_tie got %b/%h exp 01100/041", obs, mem_address);
      end
      step();
      idle_reqs();
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vec_cnt++;
         if ({obs, mem_address, mem_data_in} !== 23'h0) begin
            err_cnt++; $display("FAIL idle_c%0d got %b/%h/%h exp 0", c, obs, mem_address, mem_data_in);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_interleave();
      test_backpressure();
      test_hazard();
      test_reset_mid();
      test_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
